// File: rtl/cond_unit.sv
// NZCV flag register, ARM condition evaluation, control strobe gating and IT-block sequencer.
// CondEx/CtrlOut/Illegal are same-cycle combinational; flags and IT state update on clk when en=1.
// Optional COND_SQUASH_CNT_EN adds a saturating count of squashed retirements.
module cond_unit #(
  parameter int NUM_CTRL = 3,
  parameter int IT_DEPTH = 4,
  parameter int LW       = $clog2(IT_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [3:0]          Cond,
  input  logic [3:0]          ALUFlags,
  input  logic [1:0]          FlagW,
  input  logic [NUM_CTRL-1:0] CtrlIn,
  input  logic                ItStart,
  input  logic [3:0]          ItCond,
  input  logic [LW-1:0]       ItLen,
  input  logic [IT_DEPTH-1:0] ItThen,
  output logic [NUM_CTRL-1:0] CtrlOut,
  output logic                CondEx,
  output logic [3:0]          Flags,
  output logic                ItActive,
  output logic [LW-1:0]       ItRemain,
  output logic                Illegal
`ifdef COND_SQUASH_CNT_EN
  ,
  output logic [15:0]         SquashCnt
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state;
  logic [LW-1:0]       slot;
  logic [LW-1:0]       len_q;
  logic [3:0]          itcond_q;
  logic [IT_DEPTH-1:0] itthen_q;
  logic [IT_DEPTH-1:0] then_sh;
  logic [3:0]          eff_cond;
  logic                cond_ok;
  logic                cond_bad;
  logic                it_len_ok;
  logic                it_take;
  logic                n, z, c, v;

  assign {n, z, c, v} = Flags;
  assign then_sh      = itthen_q >> slot;

  // An "else" slot flips bit0, which selects the inverse of every ARM condition pair.
  assign eff_cond  = (state == ACTIVE) ? {itcond_q[3:1], itcond_q[0] ^ ~then_sh[0]} : Cond;
  assign it_len_ok = (ItLen != '0) && (ItLen <= LW'(IT_DEPTH));
  assign it_take   = (state == IDLE) && ItStart;

  always_comb begin
    cond_ok  = 1'b0;
    cond_bad = 1'b0;
    case (eff_cond)
      4'h0:    cond_ok = z;
      4'h1:    cond_ok = ~z;
      4'h2:    cond_ok = c;
      4'h3:    cond_ok = ~c;
      4'h4:    cond_ok = n;
      4'h5:    cond_ok = ~n;
      4'h6:    cond_ok = v;
      4'h7:    cond_ok = ~v;
      4'h8:    cond_ok = c & ~z;
      4'h9:    cond_ok = ~(c & ~z);
      4'hA:    cond_ok = (n == v);
      4'hB:    cond_ok = (n != v);
      4'hC:    cond_ok = ~z & (n == v);
      4'hD:    cond_ok = ~(~z & (n == v));
      4'hE:    cond_ok = 1'b1;
      default: cond_bad = 1'b1;
    endcase
  end

  always_comb begin
    CondEx  = cond_ok;
    Illegal = cond_bad | ((state == ACTIVE) & ItStart);
    if (it_take) begin
      CondEx  = 1'b1;
      Illegal = ~it_len_ok;
    end
  end

  assign CtrlOut  = CtrlIn & {NUM_CTRL{CondEx}};
  assign ItActive = (state == ACTIVE);
  assign ItRemain = (state == ACTIVE) ? (len_q - slot) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      slot     <= '0;
      len_q    <= '0;
      itcond_q <= '0;
      itthen_q <= '0;
      Flags    <= '0;
    end else if (en) begin
      if (CondEx && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (CondEx && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
      case (state)
        IDLE: begin
          if (ItStart && it_len_ok) begin
            state    <= ACTIVE;
            slot     <= '0;
            len_q    <= ItLen;
            itcond_q <= ItCond;
            itthen_q <= ItThen;
          end
        end
        ACTIVE: begin
          if (slot == len_q - LW'(1)) begin
            state <= IDLE;
            slot  <= '0;
          end else begin
            slot <= slot + LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COND_SQUASH_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      SquashCnt <= '0;
    end else if (en && !CondEx && SquashCnt != 16'hFFFF) begin
      SquashCnt <= SquashCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit (NUM_CTRL=3, IT_DEPTH=4).
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic [2:0] CtrlIn;
  logic       ItStart;
  logic [3:0] ItCond;
  logic [2:0] ItLen;
  logic [3:0] ItThen;
  logic [2:0] CtrlOut;
  logic       CondEx;
  logic [3:0] Flags;
  logic       ItActive;
  logic [2:0] ItRemain;
  logic       Illegal;
`ifdef COND_SQUASH_CNT_EN
  logic [15:0] SquashCnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cond_unit #(.NUM_CTRL(3), .IT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .CtrlIn(CtrlIn), .ItStart(ItStart), .ItCond(ItCond), .ItLen(ItLen), .ItThen(ItThen),
    .CtrlOut(CtrlOut), .CondEx(CondEx), .Flags(Flags), .ItActive(ItActive),
    .ItRemain(ItRemain), .Illegal(Illegal)
`ifdef COND_SQUASH_CNT_EN
    , .SquashCnt(SquashCnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    en = 1'b0; Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00; CtrlIn = 3'b000;
    ItStart = 1'b0; ItCond = 4'h0; ItLen = 3'd0; ItThen = 4'h0;
  endtask

  task automatic write_flags(input logic [3:0] f);
    set_idle;
    en = 1'b1; Cond = 4'hE; ALUFlags = f; FlagW = 2'b11;
    tick;
    set_idle;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_idle;
    #12;
    tests++; if (Flags !== 4'h0) begin fails++; $display("FAIL rst_flags got %h exp 0", Flags); end
    tests++; if (ItActive !== 1'b0) begin fails++; $display("FAIL rst_itactive got %b exp 0", ItActive); end
    tests++; if (ItRemain !== 3'd0) begin fails++; $display("FAIL rst_itremain got %0d exp 0", ItRemain); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    // Reset arriving in the middle of an IT block with two slots left.
    write_flags(4'b0110);
    en = 1'b1; ItStart = 1'b1; ItCond = 4'hE; ItLen = 3'd4; ItThen = 4'hF;
    tick;
    set_idle; en = 1'b1;
    tick;
    tick;
    #1;
    tests++; if (ItRemain !== 3'd2) begin fails++; $display("FAIL mid_it_remain got %0d exp 2", ItRemain); end
    reset = 1'b1;
    #1;
    tests++; if (Flags !== 4'h0) begin fails++; $display("FAIL rst_mid_flags got %h exp 0", Flags); end
    tests++; if (ItActive !== 1'b0) begin fails++; $display("FAIL rst_mid_itactive got %b exp 0", ItActive); end
    tests++; if (ItRemain !== 3'd0) begin fails++; $display("FAIL rst_mid_itremain got %0d exp 0", ItRemain); end
    #1;
    reset = 1'b0;
    set_idle; en = 1'b1; Cond = 4'h0;
    #1;
    tests++; if (CondEx !== 1'b0) begin fails++; $display("FAIL rst_mid_eq got %b exp 0", CondEx); end
    tick;
    set_idle;
  endtask

  task automatic test_flags_eq;
    logic [3:0] conds [8];
    logic       exps  [8];
    conds = '{4'hA, 4'hC, 4'hD, 4'h8, 4'h9, 4'h4, 4'h6, 4'h2};
    exps  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    write_flags(4'b0100);
    en = 1'b1; Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b1001; CtrlIn = 3'b111;
    #1;
    tests++; if (CtrlOut !== 3'b111) begin fails++; $display("FAIL eq_ctrlout got %b exp 111", CtrlOut); end
    tick;
    set_idle;
    #1;
    tests++; if (Flags !== 4'b1001) begin fails++; $display("FAIL eq_flags got %b exp 1001", Flags); end
    for (int i = 0; i < 8; i++) begin
      Cond = conds[i]; CtrlIn = 3'b101;
      #1;
      tests++; if (CondEx !== exps[i]) begin fails++; $display("FAIL cond_%h got %b exp %b", conds[i], CondEx, exps[i]); end
      tests++; if (CtrlOut !== (exps[i] ? 3'b101 : 3'b000)) begin fails++; $display("FAIL ctrl_%h got %b", conds[i], CtrlOut); end
    end
    set_idle;
  endtask

  task automatic test_squash_noflags;
    write_flags(4'b0000);
    Cond = 4'h1;
    #1;
    tests++; if (CondEx !== 1'b1) begin fails++; $display("FAIL ne_z0 got %b exp 1", CondEx); end
    en = 1'b1; Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b1111; CtrlIn = 3'b111;
    #1;
    tests++; if (CtrlOut !== 3'b000) begin fails++; $display("FAIL squash_ctrlout got %b exp 000", CtrlOut); end
    tick;
    set_idle;
    #1;
    tests++; if (Flags !== 4'b0000) begin fails++; $display("FAIL squash_flags got %b exp 0000", Flags); end
  endtask

  task automatic test_it_block;
    logic       exp_cx  [3];
    logic [2:0] exp_rem [3];
    exp_cx  = '{1'b1, 1'b0, 1'b1};
    exp_rem = '{3'd3, 3'd2, 3'd1};
    write_flags(4'b0100);
    en = 1'b1; ItStart = 1'b1; ItCond = 4'h0; ItLen = 3'd3; ItThen = 4'b1101;
    Cond = 4'hF; CtrlIn = 3'b111;
    #1;
    tests++; if (CondEx !== 1'b1) begin fails++; $display("FAIL it_instr_condex got %b exp 1", CondEx); end
    tests++; if (Illegal !== 1'b0) begin fails++; $display("FAIL it_instr_illegal got %b exp 0", Illegal); end
    tick;
    set_idle;
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; Cond = 4'h1; CtrlIn = 3'b111;
      ItStart = (i == 1);  ItLen = 3'd2;
      #1;
      tests++; if (CondEx !== exp_cx[i]) begin fails++; $display("FAIL it_slot%0d_condex got %b exp %b", i, CondEx, exp_cx[i]); end
      tests++; if (ItRemain !== exp_rem[i]) begin fails++; $display("FAIL it_slot%0d_remain got %0d exp %0d", i, ItRemain, exp_rem[i]); end
      tests++; if (ItActive !== 1'b1) begin fails++; $display("FAIL it_slot%0d_active got %b exp 1", i, ItActive); end
      tests++; if (Illegal !== (i == 1)) begin fails++; $display("FAIL it_slot%0d_illegal got %b exp %b", i, Illegal, (i == 1)); end
      tick;
      set_idle;
      if (i == 0) begin
        tick;
        tests++; if (ItRemain !== 3'd2) begin fails++; $display("FAIL it_stall_remain got %0d exp 2", ItRemain); end
      end
    end
    Cond = 4'h1;
    #1;
    tests++; if (ItActive !== 1'b0) begin fails++; $display("FAIL it_done_active got %b exp 0", ItActive); end
    tests++; if (CondEx !== 1'b0) begin fails++; $display("FAIL it_done_ne got %b exp 0", CondEx); end
    Cond = 4'h0;
    #1;
    tests++; if (CondEx !== 1'b1) begin fails++; $display("FAIL it_done_eq got %b exp 1", CondEx); end
  endtask

  task automatic test_illegal;
    logic [2:0] lens [2];
    lens = '{3'd0, 3'd5};
    for (int i = 0; i < 2; i++) begin
      set_idle; en = 1'b1; ItStart = 1'b1; ItLen = lens[i]; ItThen = 4'hF;
      #1;
      tests++; if (Illegal !== 1'b1) begin fails++; $display("FAIL itlen%0d_illegal got %b exp 1", lens[i], Illegal); end
      tick;
      tests++; if (ItActive !== 1'b0) begin fails++; $display("FAIL itlen%0d_state got %b exp 0", lens[i], ItActive); end
    end
    set_idle; en = 1'b1; Cond = 4'hF; CtrlIn = 3'b111;
    #1;
    tests++; if (Illegal !== 1'b1) begin fails++; $display("FAIL nv_illegal got %b exp 1", Illegal); end
    tests++; if (CondEx !== 1'b0) begin fails++; $display("FAIL nv_condex got %b exp 0", CondEx); end
    tests++; if (CtrlOut !== 3'b000) begin fails++; $display("FAIL nv_ctrlout got %b exp 000", CtrlOut); end
    tick;
    tests++; if (ItActive !== 1'b0) begin fails++; $display("FAIL nv_state got %b exp 0", ItActive); end
    // Else-slot of an AL block becomes the reserved 1111 encoding.
    set_idle; en = 1'b1; ItStart = 1'b1; ItCond = 4'hE; ItLen = 3'd1; ItThen = 4'h0;
    tick;
    set_idle; en = 1'b1; CtrlIn = 3'b111;
    #1;
    tests++; if (Illegal !== 1'b1 || CondEx !== 1'b0) begin fails++; $display("FAIL inv_al got ill=%b cx=%b exp ill=1 cx=0", Illegal, CondEx); end
    tests++; if (ItRemain !== 3'd1) begin fails++; $display("FAIL inv_al_remain got %0d exp 1", ItRemain); end
    tick;
    tests++; if (ItActive !== 1'b0) begin fails++; $display("FAIL inv_al_exit got %b exp 0", ItActive); end
    set_idle;
  endtask

`ifdef COND_SQUASH_CNT_EN
  task automatic test_squash_cnt;
    reset = 1'b1;
    set_idle;
    #3;
    reset = 1'b0;
    tick;
    en = 1'b1; Cond = 4'h0;
    for (int i = 0; i < 3; i++) tick;
    en = 1'b0;
    tick;
    tests++; if (SquashCnt !== 16'd3) begin fails++; $display("FAIL sqcnt_3 got %h exp 0003", SquashCnt); end
    en = 1'b1;
    for (int i = 0; i < 65531; i++) tick;
    tests++; if (SquashCnt !== 16'hFFFE) begin fails++; $display("FAIL sqcnt_fffe got %h exp fffe", SquashCnt); end
    for (int i = 0; i < 3; i++) tick;
    tests++; if (SquashCnt !== 16'hFFFF) begin fails++; $display("FAIL sqcnt_sat got %h exp ffff", SquashCnt); end
    set_idle;
  endtask
`endif

  initial begin
    test_reset;
    test_flags_eq;
    test_squash_noflags;
    test_it_block;
    test_illegal;
`ifdef COND_SQUASH_CNT_EN
    test_squash_cnt;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Parametrised successor to the combinational condition checker; sits between the decoder and the datapath write enables in the single-cycle core.
- Holds the NZCV flag register with grouped write enables and evaluates the 4-bit ARM condition code against the registered flags.
- Gates NUM_CTRL control strobes, such as PCS, RegW and MemW, with the result.
- Adds an IT-block sequencer: up to IT_DEPTH following instructions are predicated by a base condition or its inverse, one slot per instruction.

Parameters:
- NUM_CTRL, 3, number of control strobes gated by the condition result.
- IT_DEPTH, 4, maximum number of instructions in one IT block (1..8).
- LW, $clog2(IT_DEPTH+1), width of the IT length field (derived; do not override).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  an instruction retires this cycle; all state advances only when en=1
- Cond  in  4  condition field of the current instruction
- ALUFlags  in  4  {N,Z,C,V} produced by the current instruction
- FlagW  in  2  [1]=write N,Z; [0]=write C,V
- CtrlIn  in  NUM_CTRL  ungated control strobes
- ItStart  in  1  current instruction is an IT instruction
- ItCond  in  4  base condition of the IT block
- ItLen  in  LW  number of predicated instructions, 1..IT_DEPTH
- ItThen  in  IT_DEPTH  per slot: bit i=1 means slot i uses ItCond; 0 means it uses the inverse (ItCond[0] flipped)
- CtrlOut  out  NUM_CTRL  CtrlIn & {NUM_CTRL{CondEx}}
- CondEx  out  1  the current instruction executes
- Flags  out  4  registered {N,Z,C,V}
- ItActive  out  1  the current instruction lies inside an IT block
- ItRemain  out  LW  slots remaining, including the current one
- Illegal  out  1  single-cycle pulse on an illegal condition or IT request

Behaviour:
- Reset (asynchronous, any time, including mid-IT-block): Flags=0, state=IDLE, slot=0, ItRemain=0. All IT state is discarded.
- Outputs CondEx, CtrlOut and Illegal are combinational from the current inputs and registered state. They are valid in the same cycle; there is no added latency.
- Condition table, on registered flags:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~(C&~Z).
  - GE N==V; LT N!=V.
  - GT ~Z&(N==V); LE ~GT.
  - AL 1.
  - 1111: CondEx=0 and Illegal=1. Never X.
- Effective condition:
  - IDLE: Cond.
  - ACTIVE: ItCond with bit0 XOR ~ItThen[slot]. The Cond input is ignored.
  - Inverse of AL (1111) in ACTIVE: CondEx=0 and Illegal=1.
- Flag update, at the clk edge when en=1 and CondEx=1:
  - FlagW[1] loads N,Z.
  - FlagW[0] loads C,V.
  - A squashed instruction never writes flags.
- States:
  - IDLE: ItActive=0. When en=1 and ItStart=1, the IT instruction itself gets CondEx=1 and Cond is ignored.
    - If 1<=ItLen<=IT_DEPTH: latch ItCond, ItThen and ItLen, set slot=0, go to ACTIVE.
    - Otherwise: Illegal=1, stay in IDLE.
  - ACTIVE: ItActive=1, ItRemain=len-slot. On each en=1 cycle, slot increments.
    - When slot reaches len-1 with en=1, return to IDLE.
    - ItStart inside ACTIVE: Illegal=1, the instruction is predicated normally, and the IT request is ignored.
- en=0: no state or flag change. Outputs still reflect the current inputs.
- Flags written by slot i are seen by slot i+1 on the next cycle, from the register.

Optional Feature:
- Macro: COND_SQUASH_CNT_EN.
- Defined:
  - Adds output SquashCnt (16 bits).
  - Increments on each en=1 cycle with CondEx=0.
  - Saturates at 16'hFFFF.
  - Reset clears it to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset while ACTIVE with 2 slots remaining -> Flags=0000, ItActive=0, ItRemain=0; the next instruction with Cond=0000 and Z=0 gives CondEx=0.
- Flags=0100, Cond=0000, FlagW=11, ALUFlags=1001, CtrlIn=111 -> CtrlOut=111; next cycle Flags=1001, GE=1, GT=1 with Z=0.
- Flags=0000, Cond=0001 -> CondEx=1. Cond=0000, FlagW=11, ALUFlags=1111 -> CtrlOut=000, and Flags stays 0000 on the next edge.
- ItStart, ItCond=0000, ItLen=3, ItThen=x101, Z=1:
  - Slots give CondEx 1,0,1 with ItRemain 3,2,1.
  - The fourth instruction is back in IDLE and uses Cond.
- ItLen=0, then ItLen=5 at IT_DEPTH=4, then Cond=1111 -> Illegal=1 each time; the state stays IDLE and CondEx=0 for Cond=1111.
- With COND_SQUASH_CNT_EN: 3 squashed retirements plus 1 cycle with en=0 and CondEx=0 -> SquashCnt=3; preloading to FFFE then 3 squashes -> FFFF.
